// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU types (word, opcode, captured result) for the arbiter slice.
package alu_arbiter_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } aluop_t;
    typedef struct packed {
        word_t port_out;
        logic  negative;
        logic  overflow;
        logic  zero;
    } alu_result_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side and ALU-side bus of the shared-ALU arbiter.
// master: requesters plus the ALU (drive req/operands and ALU results, observe gnt/done/result/busy).
// slave : the arbiter (drives gnt/done/result/busy and the ALU operand lines).
interface alu_arbiter_if #(parameter int NREQ = 2);
    import alu_arbiter_pkg::*;
    logic [NREQ-1:0]         req;
    aluop_t [NREQ-1:0]       req_aluop;
    word_t [NREQ-1:0]        req_port_a;
    word_t [NREQ-1:0]        req_port_b;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    alu_result_t [NREQ-1:0]  result;
    logic                    busy;
    aluop_t                  alu_aluop;
    word_t                   alu_port_a;
    word_t                   alu_port_b;
    word_t                   alu_port_out;
    logic                    alu_negative;
    logic                    alu_overflow;
    logic                    alu_zero;
    modport master (
        output req, req_aluop, req_port_a, req_port_b,
        output alu_port_out, alu_negative, alu_overflow, alu_zero,
        input  gnt, done, result, busy, alu_aluop, alu_port_a, alu_port_b
    );
    modport slave (
        input  req, req_aluop, req_port_a, req_port_b,
        input  alu_port_out, alu_negative, alu_overflow, alu_zero,
        output gnt, done, result, busy, alu_aluop, alu_port_a, alu_port_b
    );
endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// alu_arbiter_rr_picker: combinational round-robin select, first eligible at or after the pointer.
// Ports: i_elig eligible mask, i_ptr starting index; o_valid any eligible, o_idx winner index.
module alu_arbiter_rr_picker #(
    parameter int NREQ = 2,
    parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [PTRW-1:0] i_ptr,
    output logic            o_valid,
    output logic [PTRW-1:0] o_idx
);
    // Scan offsets from farthest to nearest so the nearest eligible one wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_elig[PTRW'((int'(i_ptr) + k) % NREQ)]) begin
                o_valid = 1'b1;
                o_idx   = PTRW'((int'(i_ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin issue sequencer sharing one combinational ALU among NREQ requesters.
// Ports: i_clk clock, i_rst async active-high reset, io_bus requester/ALU bus (slave side).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    alu_arbiter_if.slave io_bus
);
    logic [PTRW-1:0]        r_ptr;
    logic                   r_valid;
    logic [PTRW-1:0]        r_id;
    aluop_t                 r_op;
    word_t                  r_a;
    word_t                  r_b;
    logic [NREQ-1:0]        r_inflight;
    logic [NREQ-1:0]        r_gnt;
    logic [NREQ-1:0]        r_done;
    alu_result_t [NREQ-1:0] r_result;
    logic [NREQ-1:0]        w_elig;
    logic                   w_win_valid;
    logic [PTRW-1:0]        w_win;
    logic [NREQ-1:0]        w_win_oh;

    assign w_elig   = io_bus.req & ~r_inflight;
    assign w_win_oh = w_win_valid ? (NREQ'(1) << w_win) : '0;

    alu_arbiter_rr_picker #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_valid (w_win_valid),
        .o_idx   (w_win)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_op       <= ALU_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_inflight <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_result   <= '0;
        end else begin
            r_valid <= w_win_valid;
            r_gnt   <= w_win_oh;
            r_done  <= r_valid ? (NREQ'(1) << r_id) : '0;
            // A done bit ends the cycle it is high in, releasing its requester on that edge.
            r_inflight <= (r_inflight & ~r_done) | w_win_oh;
            if (w_win_valid) begin
                r_id  <= w_win;
                r_op  <= io_bus.req_aluop[w_win];
                r_a   <= io_bus.req_port_a[w_win];
                r_b   <= io_bus.req_port_b[w_win];
                r_ptr <= (w_win == PTRW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            end
            if (r_valid)
                r_result[r_id] <= {io_bus.alu_port_out, io_bus.alu_negative,
                                   io_bus.alu_overflow, io_bus.alu_zero};
        end
    end

    assign io_bus.gnt        = r_gnt;
    assign io_bus.done       = r_done;
    assign io_bus.result     = r_result;
    assign io_bus.busy       = r_valid;
    assign io_bus.alu_aluop  = r_op;
    assign io_bus.alu_port_a = r_a;
    assign io_bus.alu_port_b = r_b;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU on the bus.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    alu_arbiter_if #(.NREQ(2)) bus ();

    alu_arbiter #(.NREQ(2)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU the arbiter is wired to.
    word_t w_out;
    always_comb begin
        w_out = '0;
        case (bus.alu_aluop)
            ALU_ADD: w_out = bus.alu_port_a + bus.alu_port_b;
            ALU_SUB: w_out = bus.alu_port_a - bus.alu_port_b;
            ALU_AND: w_out = bus.alu_port_a & bus.alu_port_b;
            ALU_OR:  w_out = bus.alu_port_a | bus.alu_port_b;
            ALU_XOR: w_out = bus.alu_port_a ^ bus.alu_port_b;
            ALU_SLL: w_out = bus.alu_port_a << bus.alu_port_b[4:0];
            ALU_SRL: w_out = bus.alu_port_a >> bus.alu_port_b[4:0];
            ALU_SRA: w_out = word_t'($signed(bus.alu_port_a) >>> bus.alu_port_b[4:0]);
            default: w_out = '0;
        endcase
    end
    assign bus.alu_port_out = w_out;
    assign bus.alu_negative = w_out[31];
    assign bus.alu_zero     = (w_out == '0);
    assign bus.alu_overflow =
        (bus.alu_aluop == ALU_ADD) ? ((bus.alu_port_a[31] == bus.alu_port_b[31]) && (w_out[31] != bus.alu_port_a[31])) :
        (bus.alu_aluop == ALU_SUB) ? ((bus.alu_port_a[31] != bus.alu_port_b[31]) && (w_out[31] != bus.alu_port_a[31])) :
        1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input aluop_t op, input word_t a, input word_t b);
        bus.req_aluop[r]  = op;
        bus.req_port_a[r] = a;
        bus.req_port_b[r] = b;
    endtask

    function automatic logic [63:0] res(input word_t v, input logic n, input logic o, input logic z);
        alu_result_t t;
        t = '{port_out: v, negative: n, overflow: o, zero: z};
        return 64'(t);
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.req = '0;
        set_op(0, ALU_ADD, '0, '0);
        set_op(1, ALU_ADD, '0, '0);
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_res0", 64'(bus.result[0]), 64'd0);
        chk("rst_alu_a", 64'(bus.alu_port_a), 64'd0);
        rst = 1'b0;

        // 1: single ADD 5,7
        set_op(0, ALU_ADD, 32'd5, 32'd7);
        bus.req = 2'b01;
        tick();
        chk("t1_gnt", 64'(bus.gnt), 64'b01);
        chk("t1_busy1", 64'(bus.busy), 64'd1);
        chk("t1_done0", 64'(bus.done), 64'd0);
        tick();
        chk("t1_done", 64'(bus.done), 64'b01);
        chk("t1_gnt_off", 64'(bus.gnt), 64'd0);
        chk("t1_busy0", 64'(bus.busy), 64'd0);
        chk("t1_res0", 64'(bus.result[0]), res(32'd12, 0, 0, 0));
        bus.req = 2'b00;
        tick();
        chk("t1_done_end", 64'(bus.done), 64'd0);

        // 2: simultaneous from reset, r0 SUB 3,3 and r1 SLL 1,4
        rst = 1'b1;
        set_op(0, ALU_SUB, 32'd3, 32'd3);
        set_op(1, ALU_SLL, 32'd1, 32'd4);
        bus.req = 2'b11;
        tick();
        rst = 1'b0;
        tick();
        chk("t2_gnt_r0", 64'(bus.gnt), 64'b01);
        tick();
        chk("t2_gnt_r1", 64'(bus.gnt), 64'b10);
        chk("t2_done_r0", 64'(bus.done), 64'b01);
        chk("t2_res0", 64'(bus.result[0]), res(32'd0, 0, 0, 1));
        bus.req[0] = 1'b0;
        tick();
        chk("t2_done_r1", 64'(bus.done), 64'b10);
        chk("t2_gnt_none", 64'(bus.gnt), 64'd0);
        chk("t2_res1", 64'(bus.result[1]), res(32'd16, 0, 0, 0));
        bus.req[1] = 1'b0;
        tick();

        // 3: both hold req continuously, new operands in each done cycle
        set_op(0, ALU_ADD, 32'd1, 32'd2);
        set_op(1, ALU_ADD, 32'd10, 32'd20);
        bus.req = 2'b11;
        tick();
        chk("t3_g1", 64'(bus.gnt), 64'b01);
        tick();
        chk("t3_g2", 64'(bus.gnt), 64'b10);
        chk("t3_d1", 64'(bus.done), 64'b01);
        chk("t3_r0a", 64'(bus.result[0]), res(32'd3, 0, 0, 0));
        set_op(0, ALU_ADD, 32'd100, 32'd1);
        tick();
        chk("t3_g3", 64'(bus.gnt), 64'd0);
        chk("t3_d2", 64'(bus.done), 64'b10);
        chk("t3_r1a", 64'(bus.result[1]), res(32'd30, 0, 0, 0));
        set_op(1, ALU_ADD, 32'd7, 32'd7);
        tick();
        chk("t3_g4", 64'(bus.gnt), 64'b01);
        chk("t3_d3", 64'(bus.done), 64'd0);
        tick();
        chk("t3_g5", 64'(bus.gnt), 64'b10);
        chk("t3_d4", 64'(bus.done), 64'b01);
        chk("t3_r0b", 64'(bus.result[0]), res(32'd101, 0, 0, 0));
        bus.req[0] = 1'b0;
        tick();
        chk("t3_d5", 64'(bus.done), 64'b10);
        chk("t3_r1b", 64'(bus.result[1]), res(32'd14, 0, 0, 0));
        bus.req[1] = 1'b0;
        tick();

        // 4: r1 SUB overflow, result[0] untouched
        set_op(1, ALU_SUB, 32'h8000_0000, 32'd1);
        bus.req = 2'b10;
        tick();
        chk("t4_gnt", 64'(bus.gnt), 64'b10);
        tick();
        chk("t4_done", 64'(bus.done), 64'b10);
        chk("t4_res1", 64'(bus.result[1]), res(32'h7FFF_FFFF, 0, 1, 0));
        chk("t4_res0_keep", 64'(bus.result[0]), res(32'd101, 0, 0, 0));
        bus.req = 2'b00;
        tick();

        // 5: reset while an op is in the issue register
        set_op(0, ALU_ADD, 32'd2, 32'd2);
        bus.req = 2'b01;
        tick();
        chk("t5_busy_pre", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_gnt", 64'(bus.gnt), 64'd0);
        chk("t5_res0", 64'(bus.result[0]), 64'd0);
        chk("t5_res1", 64'(bus.result[1]), 64'd0);
        bus.req = 2'b00;
        tick();
        chk("t5_no_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        tick();
        chk("t5_no_done2", 64'(bus.done), 64'd0);
        set_op(0, ALU_ADD, 32'd9, 32'd9);
        bus.req = 2'b01;
        tick();
        chk("t5_regnt", 64'(bus.gnt), 64'b01);
        tick();
        chk("t5_redone", 64'(bus.done), 64'b01);
        chk("t5_reres", 64'(bus.result[0]), res(32'd18, 0, 0, 0));
        bus.req = 2'b00;
        tick();

        // pointer now past r0: a simultaneous request favours r1
        set_op(0, ALU_ADD, 32'd1, 32'd1);
        set_op(1, ALU_ADD, 32'd2, 32'd2);
        bus.req = 2'b11;
        tick();
        chk("ptr_gnt_r1", 64'(bus.gnt), 64'b10);
        tick();
        chk("ptr_gnt_r0", 64'(bus.gnt), 64'b01);
        chk("ptr_res1", 64'(bus.result[1]), res(32'd4, 0, 0, 0));
        bus.req[1] = 1'b0;
        tick();
        chk("ptr_res0", 64'(bus.result[0]), res(32'd2, 0, 0, 0));
        bus.req[0] = 1'b0;
        tick();

        // 6: operands change during gnt cycle; no early re-grant
        set_op(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        bus.req = 2'b01;
        tick();
        chk("t6_gnt", 64'(bus.gnt), 64'b01);
        set_op(0, ALU_ADD, 32'd5, 32'd5);
        tick();
        chk("t6_done", 64'(bus.done), 64'b01);
        chk("t6_gnt_off", 64'(bus.gnt), 64'd0);
        chk("t6_res0", 64'(bus.result[0]), res(32'd0, 0, 0, 1));
        tick();
        chk("t6_no_early", 64'(bus.gnt), 64'd0);
        chk("t6_done_off", 64'(bus.done), 64'd0);
        tick();
        chk("t6_regnt", 64'(bus.gnt), 64'b01);
        tick();
        chk("t6_redone", 64'(bus.done), 64'b01);
        chk("t6_res0b", 64'(bus.result[0]), res(32'd10, 0, 0, 0));
        bus.req = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
